decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
// - Stage 2 of the MIPS core: takes the instruction from fetch, decodes it, reads the register file and presents operands plus control to the ALU stage.
// - Owns the 32x32 register file; writeBack drives its write port.
// - A busy-bit scoreboard stalls issue while a source register awaits writeback.
// PARAMETERS
// - XLEN      32  datapath / register width
// - NREGS     32  architectural registers (index width 5)
// - ALUOP_W   4   width of alu_op encoding
// PORTS
// - clock       in   1      single clock; all state on posedge
// - start       in   1      reset, asynchronous, active-high
// - stage2      in   1      fetch has a valid instruction on inst
// - inst        in   32     instruction word from fetch
// - stage2_rdy  out  1      decode accepts inst this cycle
// - stage3      out  1      decoded bundle valid toward ALU
// - stage3_rdy  in   1      ALU accepts bundle this cycle
// - rs_val      out  XLEN   operand A; rt_val out XLEN operand B
// - imm         out  XLEN   sign-extended inst[15:0]
// - dest        out  5      rd (R-type), rt (addi/lw), 0 otherwise
// - alu_op      out  4      ADD=0 SUB=1 AND=2 OR=3 SLT=4 NOP=15
// - alu_src     out  1      1 = use imm as operand B
// - reg_write, mem_read, mem_write, branch, jump  out 1 each
// - illegal     out  1      unsupported opcode/funct; bundle is NOP
// - wb_en       in   1      writeBack write strobe
// - wb_addr     in   5      writeBack target register
// - wb_data     in   XLEN   writeBack data
// BEHAVIOUR
// - Reset (start=1, async): regfile all 0, scoreboard all 0, stage3=0, all bundle outputs 0, alu_op=NOP.
// - Handshake: transfer when valid && rdy on the same edge. stage2_rdy = !stall && (!stage3 || stage3_rdy).
// - Latency: 1 cycle; bundle registered, visible the cycle after acceptance.
// - Output register holds bundle stable while stage3 && !stage3_rdy; stage3 clears on handoff with no new accept.
// - Decode: R-type op 0x00, funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; addi 0x08; lw 0x23 (ADD, alu_src, mem_read, reg_write); sw 0x2B (ADD, alu_src, mem_write); beq 0x04 (SUB, branch); j 0x02 (jump, NOP).
// - Anything else: illegal=1, alu_op=NOP, all write/mem controls 0; still passes as a bundle.
// - Regfile: write on posedge when wb_en && wb_addr!=0. Reg 0 always reads 0.
// - Read bypass: if wb_en && wb_addr==src && src!=0 same cycle, operand takes wb_data.
// - Scoreboard: busy[dest] set on accept when reg_write && dest!=0; cleared on wb_en at wb_addr.
// - Same-cycle set and clear of one register: set wins.
// - stall = stage2 && (busy[rs] || (busy[rt] && inst reads rt)), ignoring bits cleared by a same-cycle wb_en (bypass covers them).
// - Reads rt: R-type, sw, beq. busy[0] never set.
// - Reset mid-operation: bundle dropped, scoreboard cleared, regfile zeroed; no partial state survives.
// STRUCTURE
// - Shared package mips_pkg: opcode/funct localparams, ALU_* codes, XLEN, REG_W=5.
// - Sub-module decode_regfile: 2 read + 1 write ports, x0 hardwired, write-to-read bypass.
// - Top holds decoder logic, scoreboard, output register.
// TESTING
// - Reset: start=1 mid-run -> stage3=0, alu_op=15, rs_val=0, regfile reads 0 after release.
// - Preload r1=5, r2=7 via wb; inst add r3,r1,r2 (0x00221820) -> next cycle rs_val=5, rt_val=7, dest=3, alu_op=0, reg_write=1.
// - lw r4,8(r1) (0x8C240008) then add r5,r4,r4 -> add stalls (stage2_rdy=0) until wb_en r4=9; accepted with rs_val=rt_val=9.
// - wb_en r6=0x1234 same cycle as or r7,r6,r0 is accepted -> rs_val=0x1234 via bypass.
// - stage3_rdy=0 for 3 cycles with add queued -> bundle held stable; stage2_rdy=0; resumes on stage3_rdy=1.
// - addi r0,r0,1 and opcode 0x3F -> dest=0, busy unchanged, reads 0; 0x3F gives illegal=1, alu_op=15.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS decode stage: datapath widths, opcode and
// funct encodings, ALU operation codes, the decoded bundle record and a
// sign-extension helper.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam int XLEN    = 32;
   localparam int NREGS   = 32;
   localparam int REG_W   = 5;
   localparam int ALUOP_W = 4;

   // Primary opcodes (inst[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes (inst[5:0])
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [ALUOP_W-1:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_SLT = 4'd4,
      ALU_NOP = 4'd15
   } alu_op_e;

   // Everything handed to the ALU stage in one registered word.
   typedef struct packed {
      logic [XLEN-1:0]  rs_val;
      logic [XLEN-1:0]  rt_val;
      logic [XLEN-1:0]  imm;
      logic [REG_W-1:0] dest;
      alu_op_e          alu_op;
      logic             alu_src;
      logic             reg_write;
      logic             mem_read;
      logic             mem_write;
      logic             branch;
      logic             jump;
      logic             illegal;
   } bundle_t;

   function automatic logic [XLEN-1:0] sign_ext16(input logic [15:0] v);
      return {{(XLEN-16){v[15]}}, v};
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// -----------------------------------------------------------------------------
// decode_stage_if
// Handshake and bundle signals around the decode stage.
//   Fetch side : stage2 (valid), inst, stage2_rdy
//   ALU side   : stage3 (valid), stage3_rdy, rs_val, rt_val, imm, dest,
//                alu_op, alu_src, reg_write, mem_read, mem_write, branch,
//                jump, illegal
// Modports: slave = the decode stage, master = its environment
// (fetch driving instructions, ALU consuming bundles).
// -----------------------------------------------------------------------------
interface decode_stage_if;
   import mips_pkg::*;

   logic                stage2;
   logic [XLEN-1:0]     inst;
   logic                stage2_rdy;
   logic                stage3;
   logic                stage3_rdy;
   logic [XLEN-1:0]     rs_val;
   logic [XLEN-1:0]     rt_val;
   logic [XLEN-1:0]     imm;
   logic [REG_W-1:0]    dest;
   logic [ALUOP_W-1:0]  alu_op;
   logic                alu_src;
   logic                reg_write;
   logic                mem_read;
   logic                mem_write;
   logic                branch;
   logic                jump;
   logic                illegal;

   modport slave (
      input  stage2, inst, stage3_rdy,
      output stage2_rdy, stage3, rs_val, rt_val, imm, dest, alu_op,
             alu_src, reg_write, mem_read, mem_write, branch, jump, illegal
   );

   modport master (
      output stage2, inst, stage3_rdy,
      input  stage2_rdy, stage3, rs_val, rt_val, imm, dest, alu_op,
             alu_src, reg_write, mem_read, mem_write, branch, jump, illegal
   );

endinterface

// File: rtl/decode_regfile.sv
// -----------------------------------------------------------------------------
// decode_regfile
// 32 x XLEN register file, two asynchronous read ports and one write port.
// Register 0 is hardwired to zero. A write presented in the same cycle as a
// read of the same (non-zero) register is forwarded to the read port.
// Ports:
//   clock_i, rst_i          clock, asynchronous active-high reset (zeroes all)
//   ra_a_i / rd_a_o         read port A address / data
//   ra_b_i / rd_b_o         read port B address / data
//   we_i, wa_i, wd_i        write strobe, address, data
// -----------------------------------------------------------------------------
module decode_regfile
   import mips_pkg::*;
(
   input  logic             clock_i,
   input  logic             rst_i,
   input  logic [REG_W-1:0] ra_a_i,
   output logic [XLEN-1:0]  rd_a_o,
   input  logic [REG_W-1:0] ra_b_i,
   output logic [XLEN-1:0]  rd_b_o,
   input  logic             we_i,
   input  logic [REG_W-1:0] wa_i,
   input  logic [XLEN-1:0]  wd_i
);

   logic [XLEN-1:0] rf_q [NREGS];

   always_ff @(posedge clock_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREGS; i++) begin
            rf_q[i] <= '0;
         end
      end else if (we_i && (wa_i != '0)) begin
         rf_q[wa_i] <= wd_i;
      end
   end

   function automatic logic [XLEN-1:0] read_port(input logic [REG_W-1:0] ra,
                                                 input logic [XLEN-1:0]  stored);
      if (ra == '0)
         return '0;
      else if (we_i && (wa_i == ra))
         return wd_i;
      else
         return stored;
   endfunction

   assign rd_a_o = read_port(ra_a_i, rf_q[ra_a_i]);
   assign rd_b_o = read_port(ra_b_i, rf_q[ra_b_i]);

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Stage 2 of the MIPS core. Decodes the instruction from fetch, reads the
// register file and registers an operand/control bundle for the ALU stage.
// A per-register busy scoreboard holds issue back while a source register is
// still waiting for its writeback.
// Ports:
//   clock                 clock, all state on posedge
//   start                 asynchronous active-high reset
//   bus (slave)           fetch handshake (stage2/inst/stage2_rdy) and ALU
//                         handshake plus bundle (stage3/stage3_rdy/...)
//   wb_en, wb_addr,       writeBack port into the register file; also
//   wb_data               clears the scoreboard bit of wb_addr
// -----------------------------------------------------------------------------
module decode_stage
   import mips_pkg::*;
(
   input  logic             clock,
   input  logic             start,
   decode_stage_if.slave    bus,
   input  logic             wb_en,
   input  logic [REG_W-1:0] wb_addr,
   input  logic [XLEN-1:0]  wb_data
);

   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic [REG_W-1:0] rs;
   logic [REG_W-1:0] rt;
   logic [REG_W-1:0] rd;

   assign opcode = bus.inst[31:26];
   assign rs     = bus.inst[25:21];
   assign rt     = bus.inst[20:16];
   assign rd     = bus.inst[15:11];
   assign funct  = bus.inst[5:0];

   logic [XLEN-1:0] rd_a;
   logic [XLEN-1:0] rd_b;

   decode_regfile u_regfile (
      .clock_i (clock),
      .rst_i   (start),
      .ra_a_i  (rs),
      .rd_a_o  (rd_a),
      .ra_b_i  (rt),
      .rd_b_o  (rd_b),
      .we_i    (wb_en),
      .wa_i    (wb_addr),
      .wd_i    (wb_data)
   );

   // Decoder: unsupported encodings still flow as a bundle, but as a NOP
   // with every write/memory control forced low.
   bundle_t bundle_d;
   logic    reads_rt;

   always_comb begin
      bundle_d        = '0;
      bundle_d.alu_op = ALU_NOP;
      bundle_d.imm    = sign_ext16(bus.inst[15:0]);
      bundle_d.rs_val = rd_a;
      bundle_d.rt_val = rd_b;
      reads_rt        = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            reads_rt           = 1'b1;
            bundle_d.reg_write = 1'b1;
            bundle_d.dest      = rd;
            case (funct)
               FN_ADD:  bundle_d.alu_op = ALU_ADD;
               FN_SUB:  bundle_d.alu_op = ALU_SUB;
               FN_AND:  bundle_d.alu_op = ALU_AND;
               FN_OR:   bundle_d.alu_op = ALU_OR;
               FN_SLT:  bundle_d.alu_op = ALU_SLT;
               default: begin
                  bundle_d.illegal   = 1'b1;
                  bundle_d.reg_write = 1'b0;
                  bundle_d.dest      = '0;
               end
            endcase
         end
         OP_ADDI: begin
            bundle_d.alu_op    = ALU_ADD;
            bundle_d.alu_src   = 1'b1;
            bundle_d.reg_write = 1'b1;
            bundle_d.dest      = rt;
         end
         OP_LW: begin
            bundle_d.alu_op    = ALU_ADD;
            bundle_d.alu_src   = 1'b1;
            bundle_d.mem_read  = 1'b1;
            bundle_d.reg_write = 1'b1;
            bundle_d.dest      = rt;
         end
         OP_SW: begin
            reads_rt           = 1'b1;
            bundle_d.alu_op    = ALU_ADD;
            bundle_d.alu_src   = 1'b1;
            bundle_d.mem_write = 1'b1;
         end
         OP_BEQ: begin
            reads_rt         = 1'b1;
            bundle_d.alu_op  = ALU_SUB;
            bundle_d.branch  = 1'b1;
         end
         OP_J: begin
            bundle_d.jump    = 1'b1;
         end
         default: begin
            bundle_d.illegal = 1'b1;
         end
      endcase
   end

   // Scoreboard. A writeback landing this cycle already reaches the operand
   // through the regfile bypass, so its busy bit is masked before the stall
   // decision.
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [NREGS-1:0] wb_clr;
   logic [NREGS-1:0] busy_eff;
   logic             stall;
   logic             stage3_q;
   logic             accept;
   bundle_t          bundle_q;

   always_comb begin
      wb_clr = '0;
      if (wb_en)
         wb_clr[wb_addr] = 1'b1;
   end

   assign busy_eff = busy_q & ~wb_clr;
   assign stall    = bus.stage2 && (busy_eff[rs] || (reads_rt && busy_eff[rt]));
   assign bus.stage2_rdy = !stall && (!stage3_q || bus.stage3_rdy);
   assign accept   = bus.stage2 && bus.stage2_rdy;

   // Set is applied after clear so a same-cycle set/clear of one register
   // leaves it busy.
   always_comb begin
      busy_d = busy_eff;
      if (accept && bundle_d.reg_write && (bundle_d.dest != '0))
         busy_d[bundle_d.dest] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clock or posedge start) begin
      if (start) begin
         stage3_q        <= 1'b0;
         busy_q          <= '0;
         bundle_q        <= '0;
         bundle_q.alu_op <= ALU_NOP;
      end else begin
         busy_q <= busy_d;
         if (accept) begin
            stage3_q <= 1'b1;
            bundle_q <= bundle_d;
         end else if (bus.stage3_rdy) begin
            stage3_q <= 1'b0;
         end
      end
   end

   assign bus.stage3    = stage3_q;
   assign bus.rs_val    = bundle_q.rs_val;
   assign bus.rt_val    = bundle_q.rt_val;
   assign bus.imm       = bundle_q.imm;
   assign bus.dest      = bundle_q.dest;
   assign bus.alu_op    = bundle_q.alu_op;
   assign bus.alu_src   = bundle_q.alu_src;
   assign bus.reg_write = bundle_q.reg_write;
   assign bus.mem_read  = bundle_q.mem_read;
   assign bus.mem_write = bundle_q.mem_write;
   assign bus.branch    = bundle_q.branch;
   assign bus.jump      = bundle_q.jump;
   assign bus.illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Directed scenarios followed by a randomized run against a reference model
// of the decode stage (architectural register array, pending-write set and
// a single expected output bundle).
// -----------------------------------------------------------------------------
module tb_decode_stage;
   import mips_pkg::*;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [4:0]  dest;
      logic [3:0]  op;
      logic        src;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        br;
      logic        jp;
      logic        ill;
   } exp_t;

   logic        clock = 1'b0;
   logic        start;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   decode_stage_if bus();

   decode_stage dut (
      .clock   (clock),
      .start   (start),
      .bus     (bus),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data)
   );

   always #5 clock = ~clock;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] mdl_rf [32];
   bit          mdl_busy [32];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic exp_t actual();
      return {bus.rs_val, bus.rt_val, bus.imm, bus.dest, bus.alu_op, bus.alu_src,
              bus.reg_write, bus.mem_read, bus.mem_write, bus.branch, bus.jump,
              bus.illegal};
   endfunction

   function automatic logic [31:0] ref_read(input logic [4:0] r, input logic wbe,
                                            input logic [4:0] wba, input logic [31:0] wbd);
      if (r == 5'd0) return 32'd0;
      if (wbe && wba == r) return wbd;
      return mdl_rf[r];
   endfunction

   function automatic bit ref_reads_rt(input logic [31:0] ins);
      return (ins[31:26] == 6'h00) || (ins[31:26] == 6'h2B) || (ins[31:26] == 6'h04);
   endfunction

   // Instruction table: what each supported encoding means to the ALU stage.
   function automatic exp_t ref_decode(input logic [31:0] ins, input logic wbe,
                                       input logic [4:0] wba, input logic [31:0] wbd);
      exp_t e;
      e     = '0;
      e.a   = ref_read(ins[25:21], wbe, wba, wbd);
      e.b   = ref_read(ins[20:16], wbe, wba, wbd);
      e.imm = {{16{ins[15]}}, ins[15:0]};
      e.op  = 4'd15;
      case (ins[31:26])
         6'h00: begin
            e.rw = 1'b1; e.dest = ins[15:11];
            if      (ins[5:0] == 6'h20) e.op = 4'd0;
            else if (ins[5:0] == 6'h22) e.op = 4'd1;
            else if (ins[5:0] == 6'h24) e.op = 4'd2;
            else if (ins[5:0] == 6'h25) e.op = 4'd3;
            else if (ins[5:0] == 6'h2A) e.op = 4'd4;
            else begin e.ill = 1'b1; e.rw = 1'b0; e.dest = 5'd0; end
         end
         6'h08: begin e.op = 4'd0; e.src = 1'b1; e.rw = 1'b1; e.dest = ins[20:16]; end
         6'h23: begin e.op = 4'd0; e.src = 1'b1; e.rw = 1'b1; e.mr = 1'b1; e.dest = ins[20:16]; end
         6'h2B: begin e.op = 4'd0; e.src = 1'b1; e.mw = 1'b1; end
         6'h04: begin e.op = 4'd1; e.br = 1'b1; end
         6'h02: begin e.jp = 1'b1; end
         default: e.ill = 1'b1;
      endcase
      return e;
   endfunction

   // Model bookkeeping for an accepted instruction.
   task automatic note_accept(input logic [31:0] ins);
      exp_t e;
      e = ref_decode(ins, 1'b0, 5'd0, 32'd0);
      if (e.rw && e.dest != 5'd0) mdl_busy[e.dest] = 1'b1;
   endtask

   task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
      wb_en = 1'b1; wb_addr = a; wb_data = d;
      tick();
      wb_en = 1'b0;
      if (a != 5'd0) mdl_rf[a] = d;
      mdl_busy[a] = 1'b0;
   endtask

   task automatic drain_busy();
      for (int r = 1; r < 32; r++)
         if (mdl_busy[r]) wb_write(r[4:0], $urandom);
   endtask

   task automatic model_clear();
      for (int r = 0; r < 32; r++) begin
         mdl_rf[r] = 32'd0; mdl_busy[r] = 1'b0;
      end
   endtask

   task automatic test_reset();
      start = 1'b1; bus.stage2 = 1'b0; bus.inst = 32'd0; bus.stage3_rdy = 1'b1;
      wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
      model_clear();
      #2;
      n_cmp++;
      if ({bus.stage3, bus.alu_op, bus.rs_val, bus.reg_write} !== {1'b0, 4'd15, 32'd0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_state got stage3=%0b alu_op=%0d rs_val=%h rw=%0b want 0/15/0/0",
                  bus.stage3, bus.alu_op, bus.rs_val, bus.reg_write);
      end
      tick(); tick();
      start = 1'b0;
      tick();
   endtask

   task automatic test_add();
      wb_write(5'd1, 32'd5);
      wb_write(5'd2, 32'd7);
      bus.stage2 = 1'b1; bus.inst = 32'h00221820; bus.stage3_rdy = 1'b1;
      #1;
      n_cmp++;
      if (bus.stage2_rdy !== 1'b1) begin
         n_err++; $display("FAIL add_rdy got %0b want 1", bus.stage2_rdy);
      end
      tick();
      note_accept(32'h00221820);
      bus.stage2 = 1'b0;
      n_cmp++;
      if ({bus.stage3, bus.rs_val, bus.rt_val, bus.dest, bus.alu_op, bus.reg_write} !==
          {1'b1, 32'd5, 32'd7, 5'd3, 4'd0, 1'b1}) begin
         n_err++;
         $display("FAIL add_bundle got v=%0b rs=%0d rt=%0d dest=%0d op=%0d rw=%0b want 1/5/7/3/0/1",
                  bus.stage3, bus.rs_val, bus.rt_val, bus.dest, bus.alu_op, bus.reg_write);
      end
      tick();
      n_cmp++;
      if (bus.stage3 !== 1'b0) begin
         n_err++; $display("FAIL add_handoff stage3 got %0b want 0", bus.stage3);
      end
      drain_busy();
   endtask

   task automatic test_lw_stall();
      bus.stage2 = 1'b1; bus.inst = 32'h8C240008; bus.stage3_rdy = 1'b1;
      tick();
      note_accept(32'h8C240008);
      bus.inst = 32'h00842820;
      #1;
      n_cmp++;
      if ({bus.rs_val, bus.imm, bus.dest, bus.alu_op, bus.alu_src, bus.mem_read, bus.reg_write} !==
          {32'd5, 32'd8, 5'd4, 4'd0, 1'b1, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL lw_bundle got rs=%0d imm=%0d dest=%0d op=%0d src=%0b mr=%0b rw=%0b want 5/8/4/0/1/1/1",
                  bus.rs_val, bus.imm, bus.dest, bus.alu_op, bus.alu_src, bus.mem_read, bus.reg_write);
      end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (bus.stage2_rdy !== 1'b0) begin
            n_err++; $display("FAIL lw_stall cycle %0d stage2_rdy got %0b want 0", i, bus.stage2_rdy);
         end
         tick();
         #1;
      end
      n_cmp++;
      if (bus.stage3 !== 1'b0) begin
         n_err++; $display("FAIL lw_stall_bubble stage3 got %0b want 0", bus.stage3);
      end
      wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'd9;
      #1;
      n_cmp++;
      if (bus.stage2_rdy !== 1'b1) begin
         n_err++; $display("FAIL lw_release stage2_rdy got %0b want 1", bus.stage2_rdy);
      end
      tick();
      wb_en = 1'b0; mdl_rf[4] = 32'd9; mdl_busy[4] = 1'b0;
      note_accept(32'h00842820);
      bus.stage2 = 1'b0;
      n_cmp++;
      if ({bus.stage3, bus.rs_val, bus.rt_val, bus.dest} !== {1'b1, 32'd9, 32'd9, 5'd5}) begin
         n_err++;
         $display("FAIL lw_dep_add got v=%0b rs=%0d rt=%0d dest=%0d want 1/9/9/5",
                  bus.stage3, bus.rs_val, bus.rt_val, bus.dest);
      end
      tick();
      drain_busy();
   endtask

   task automatic test_bypass();
      bus.stage2 = 1'b1; bus.inst = 32'h00C03825; bus.stage3_rdy = 1'b1;
      wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h1234;
      #1;
      n_cmp++;
      if (bus.stage2_rdy !== 1'b1) begin
         n_err++; $display("FAIL bypass_rdy got %0b want 1", bus.stage2_rdy);
      end
      tick();
      wb_en = 1'b0; mdl_rf[6] = 32'h1234;
      note_accept(32'h00C03825);
      bus.stage2 = 1'b0;
      n_cmp++;
      if ({bus.rs_val, bus.rt_val, bus.alu_op, bus.dest} !== {32'h1234, 32'd0, 4'd3, 5'd7}) begin
         n_err++;
         $display("FAIL bypass_or got rs=%h rt=%h op=%0d dest=%0d want 1234/0/3/7",
                  bus.rs_val, bus.rt_val, bus.alu_op, bus.dest);
      end
      tick();
      drain_busy();
   endtask

   task automatic test_backpressure();
      bus.stage2 = 1'b1; bus.inst = 32'h00221820; bus.stage3_rdy = 1'b0;
      tick();
      note_accept(32'h00221820);
      bus.inst = 32'h00224022;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if ({bus.stage2_rdy, bus.stage3, bus.rs_val, bus.rt_val, bus.alu_op, bus.dest} !==
             {1'b0, 1'b1, 32'd5, 32'd7, 4'd0, 5'd3}) begin
            n_err++;
            $display("FAIL hold cycle %0d got rdy=%0b v=%0b rs=%0d rt=%0d op=%0d dest=%0d want 0/1/5/7/0/3",
                     i, bus.stage2_rdy, bus.stage3, bus.rs_val, bus.rt_val, bus.alu_op, bus.dest);
         end
         tick();
      end
      bus.stage3_rdy = 1'b1;
      #1;
      n_cmp++;
      if (bus.stage2_rdy !== 1'b1) begin
         n_err++; $display("FAIL hold_resume stage2_rdy got %0b want 1", bus.stage2_rdy);
      end
      tick();
      note_accept(32'h00224022);
      bus.stage2 = 1'b0;
      n_cmp++;
      if ({bus.stage3, bus.alu_op, bus.dest, bus.rs_val} !== {1'b1, 4'd1, 5'd8, 32'd5}) begin
         n_err++;
         $display("FAIL hold_next got v=%0b op=%0d dest=%0d rs=%0d want 1/1/8/5",
                  bus.stage3, bus.alu_op, bus.dest, bus.rs_val);
      end
      tick();
      n_cmp++;
      if (bus.stage3 !== 1'b0) begin
         n_err++; $display("FAIL hold_drain stage3 got %0b want 0", bus.stage3);
      end
      drain_busy();
   endtask

   task automatic test_r0_illegal();
      bus.stage2 = 1'b1; bus.inst = 32'h20000001; bus.stage3_rdy = 1'b1;
      tick();
      note_accept(32'h20000001);
      bus.inst = 32'h00004820;
      #1;
      n_cmp++;
      if ({bus.dest, bus.reg_write, bus.alu_op, bus.alu_src, bus.imm, bus.stage2_rdy} !==
          {5'd0, 1'b1, 4'd0, 1'b1, 32'd1, 1'b1}) begin
         n_err++;
         $display("FAIL addi_r0 got dest=%0d rw=%0b op=%0d src=%0b imm=%0d rdy=%0b want 0/1/0/1/1/1",
                  bus.dest, bus.reg_write, bus.alu_op, bus.alu_src, bus.imm, bus.stage2_rdy);
      end
      tick();
      note_accept(32'h00004820);
      bus.inst = 32'hFC000000;
      #1;
      n_cmp++;
      if ({bus.rs_val, bus.rt_val, bus.dest} !== {32'd0, 32'd0, 5'd9}) begin
         n_err++;
         $display("FAIL r0_reads got rs=%h rt=%h dest=%0d want 0/0/9", bus.rs_val, bus.rt_val, bus.dest);
      end
      tick();
      bus.stage2 = 1'b0;
      n_cmp++;
      if ({bus.stage3, bus.illegal, bus.alu_op, bus.reg_write, bus.mem_read, bus.mem_write, bus.dest} !==
          {1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 5'd0}) begin
         n_err++;
         $display("FAIL illegal_op got v=%0b ill=%0b op=%0d rw=%0b mr=%0b mw=%0b dest=%0d want 1/1/15/0/0/0/0",
                  bus.stage3, bus.illegal, bus.alu_op, bus.reg_write, bus.mem_read, bus.mem_write, bus.dest);
      end
      tick();
      drain_busy();
   endtask

   task automatic test_reset_mid();
      bus.stage2 = 1'b1; bus.inst = 32'h8C240008; bus.stage3_rdy = 1'b0;
      tick();
      bus.stage2 = 1'b0;
      #2;
      start = 1'b1;
      #1;
      n_cmp++;
      if ({bus.stage3, bus.alu_op, bus.rs_val} !== {1'b0, 4'd15, 32'd0}) begin
         n_err++;
         $display("FAIL reset_mid got v=%0b op=%0d rs=%h want 0/15/0", bus.stage3, bus.alu_op, bus.rs_val);
      end
      tick();
      start = 1'b0;
      model_clear();
      bus.stage3_rdy = 1'b1;
      bus.stage2 = 1'b1; bus.inst = 32'h00842820;
      #1;
      n_cmp++;
      if (bus.stage2_rdy !== 1'b1) begin
         n_err++; $display("FAIL reset_scoreboard stage2_rdy got %0b want 1", bus.stage2_rdy);
      end
      tick();
      note_accept(32'h00842820);
      bus.inst = 32'h00221820;
      tick();
      note_accept(32'h00221820);
      bus.stage2 = 1'b0;
      n_cmp++;
      if ({bus.stage3, bus.rs_val, bus.rt_val, bus.dest} !== {1'b1, 32'd0, 32'd0, 5'd3}) begin
         n_err++;
         $display("FAIL reset_regfile got v=%0b rs=%h rt=%h dest=%0d want 1/0/0/3",
                  bus.stage3, bus.rs_val, bus.rt_val, bus.dest);
      end
      tick();
      drain_busy();
   endtask

   function automatic logic [31:0] gen_inst();
      logic [4:0]  rs, rt, rd;
      logic [15:0] im;
      logic [5:0]  fn;
      int          k;
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      im = 16'($urandom);
      k  = $urandom_range(0, 9);
      case (k)
         0, 1, 2: begin
            case ($urandom_range(0, 5))
               0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24;
               3: fn = 6'h25; 4: fn = 6'h2A; default: fn = 6'h21;
            endcase
            return {6'h00, rs, rt, rd, 5'd0, fn};
         end
         3: return {6'h08, rs, rt, im};
         4: return {6'h23, rs, rt, im};
         5: return {6'h2B, rs, rt, im};
         6: return {6'h04, rs, rt, im};
         7: return {6'h02, 26'($urandom)};
         8: return {6'h3F, rs, rt, im};
         default: return {6'h08, rs, rt, im};
      endcase
   endfunction

   task automatic test_random();
      exp_t        cur, nxt;
      bit          cur_v, exp_rdy, acc, stall_m;
      bit          busy_e [32];
      logic [31:0] ins;
      int          q [$];
      cur   = '0;
      cur_v = 1'b0;
      nxt   = '0;
      for (int c = 0; c < 400; c++) begin
         ins = gen_inst();
         bus.inst       = ins;
         bus.stage2     = ($urandom_range(0, 3) != 0);
         bus.stage3_rdy = ($urandom_range(0, 3) != 0);
         q.delete();
         for (int r = 1; r < 8; r++) if (mdl_busy[r]) q.push_back(r);
         wb_en = 1'b0; wb_addr = 5'd0; wb_data = $urandom;
         if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
            wb_en = 1'b1; wb_addr = 5'(q[$urandom_range(0, q.size() - 1)]);
         end else if ($urandom_range(0, 5) == 0) begin
            wb_en = 1'b1; wb_addr = 5'($urandom_range(0, 7));
         end
         #1;
         for (int r = 0; r < 32; r++) busy_e[r] = mdl_busy[r];
         if (wb_en) busy_e[wb_addr] = 1'b0;
         stall_m = bus.stage2 && (busy_e[ins[25:21]] || (ref_reads_rt(ins) && busy_e[ins[20:16]]));
         exp_rdy = !stall_m && (!cur_v || bus.stage3_rdy);
         n_cmp++;
         if (bus.stage2_rdy !== exp_rdy) begin
            n_err++;
            $display("FAIL rand_rdy cycle %0d inst=%h got %0b want %0b", c, ins, bus.stage2_rdy, exp_rdy);
         end
         acc = bus.stage2 && exp_rdy;
         if (acc) nxt = ref_decode(ins, wb_en, wb_addr, wb_data);
         tick();
         if (wb_en) begin
            if (wb_addr != 5'd0) mdl_rf[wb_addr] = wb_data;
            mdl_busy[wb_addr] = 1'b0;
         end
         if (acc && nxt.rw && nxt.dest != 5'd0) mdl_busy[nxt.dest] = 1'b1;
         if (acc) begin
            cur = nxt; cur_v = 1'b1;
         end else if (bus.stage3_rdy) begin
            cur_v = 1'b0;
         end
         wb_en = 1'b0;
         n_cmp++;
         if (bus.stage3 !== cur_v) begin
            n_err++; $display("FAIL rand_valid cycle %0d got %0b want %0b", c, bus.stage3, cur_v);
         end else if (cur_v) begin
            n_cmp++;
            if (actual() !== cur) begin
               n_err++;
               $display("FAIL rand_bundle cycle %0d got %h want %h", c, actual(), cur);
            end
         end
      end
      bus.stage2 = 1'b0; bus.stage3_rdy = 1'b1;
      tick();
      drain_busy();
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw_stall();
      test_bypass();
      test_backpressure();
      test_r0_illegal();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
